// File: rtl/pipe_stage_regs.sv
// Fetch PC register plus IF/ID and ID/EX pipeline registers for a 5-stage RISC-V core.
// Applies hazard-unit stall/flush requests per stage and keeps saturating stall/flush event counters.
module pipe_stage_regs #(
   parameter int                XLEN     = 32,
   parameter int                CTRL_W   = 16,
   parameter logic [XLEN-1:0]   RESET_PC = '0,
   parameter int                CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall_f,
   input  logic              stall_d,
   input  logic              flush_d,
   input  logic              flush_e,
   input  logic              cnt_clr,
   input  logic [XLEN-1:0]   pc_next_f,
   input  logic [31:0]       instr_f,
   input  logic [CTRL_W-1:0] ctrl_d,
   input  logic [4:0]        rs1_d,
   input  logic [4:0]        rs2_d,
   input  logic [4:0]        rd_d,
   input  logic [XLEN-1:0]   rd1_d,
   input  logic [XLEN-1:0]   rd2_d,
   input  logic [XLEN-1:0]   imm_d,
   output logic [XLEN-1:0]   pc_f,
   output logic [31:0]       instr_d,
   output logic [XLEN-1:0]   pc_d,
   output logic [XLEN-1:0]   pc_plus4_d,
   output logic              valid_d,
   output logic [CTRL_W-1:0] ctrl_e,
   output logic [4:0]        rs1_e,
   output logic [4:0]        rs2_e,
   output logic [4:0]        rd_e,
   output logic [XLEN-1:0]   rd1_e,
   output logic [XLEN-1:0]   rd2_e,
   output logic [XLEN-1:0]   imm_e,
   output logic [XLEN-1:0]   pc_e,
   output logic [XLEN-1:0]   pc_plus4_e,
   output logic              valid_e,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   logic stall_inc;
   logic stall_sat;
   logic flush_sat;

   assign stall_inc = stall_d && !flush_d;
   assign stall_sat = &stall_cnt;
   assign flush_sat = &flush_cnt;

   // A redirect must win over a fetch stall, otherwise a taken branch would be lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_f <= RESET_PC;
      end else if (flush_d || !stall_f) begin
         pc_f <= pc_next_f;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_d    <= '0;
         pc_d       <= '0;
         pc_plus4_d <= '0;
         valid_d    <= 1'b0;
      end else if (flush_d) begin
         instr_d    <= NOP_INSTR;
         pc_d       <= '0;
         pc_plus4_d <= '0;
         valid_d    <= 1'b0;
      end else if (!stall_d) begin
         instr_d    <= instr_f;
         pc_d       <= pc_f;
         pc_plus4_d <= pc_f + XLEN'(4);
         valid_d    <= 1'b1;
      end
   end

   // ID/EX never holds: a bubble here keeps a stalled D instruction from issuing twice.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_e     <= '0;
         rs1_e      <= '0;
         rs2_e      <= '0;
         rd_e       <= '0;
         rd1_e      <= '0;
         rd2_e      <= '0;
         imm_e      <= '0;
         pc_e       <= '0;
         pc_plus4_e <= '0;
         valid_e    <= 1'b0;
      end else if (flush_e) begin
         ctrl_e     <= '0;
         rs1_e      <= '0;
         rs2_e      <= '0;
         rd_e       <= '0;
         rd1_e      <= '0;
         rd2_e      <= '0;
         imm_e      <= '0;
         pc_e       <= '0;
         pc_plus4_e <= '0;
         valid_e    <= 1'b0;
      end else begin
         ctrl_e     <= ctrl_d;
         rs1_e      <= rs1_d;
         rs2_e      <= rs2_d;
         rd_e       <= rd_d;
         rd1_e      <= rd1_d;
         rd2_e      <= rd2_d;
         imm_e      <= imm_d;
         pc_e       <= pc_d;
         pc_plus4_e <= pc_plus4_d;
         valid_e    <= valid_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (cnt_clr) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_inc && !stall_sat) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
         if (flush_d && !flush_sat) begin
            flush_cnt <= flush_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Directed bench for pipe_stage_regs: reset, free flow, load-use, branch, stall+flush,
// PC wrap, counter saturation/clear and asynchronous mid-stream reset.
module tb_pipe_stage_regs;

   logic        clk;
   logic        rst_n;
   logic        stall_f;
   logic        stall_d;
   logic        flush_d;
   logic        flush_e;
   logic        cnt_clr;
   logic [31:0] pc_next_f;
   logic [31:0] instr_f;
   logic [15:0] ctrl_d;
   logic [4:0]  rs1_d;
   logic [4:0]  rs2_d;
   logic [4:0]  rd_d;
   logic [31:0] rd1_d;
   logic [31:0] rd2_d;
   logic [31:0] imm_d;
   logic [31:0] pc_f;
   logic [31:0] instr_d;
   logic [31:0] pc_d;
   logic [31:0] pc_plus4_d;
   logic        valid_d;
   logic [15:0] ctrl_e;
   logic [4:0]  rs1_e;
   logic [4:0]  rs2_e;
   logic [4:0]  rd_e;
   logic [31:0] rd1_e;
   logic [31:0] rd2_e;
   logic [31:0] imm_e;
   logic [31:0] pc_e;
   logic [31:0] pc_plus4_e;
   logic        valid_e;
   logic [3:0]  stall_cnt;
   logic [3:0]  flush_cnt;

   logic        redirect;
   logic [31:0] target;
   int          errors;
   int          checks;

   // Stimulus-side fetch/decode: instruction word tagged by PC, rd field = 31.
   assign pc_next_f = redirect ? target : pc_f + 32'd4;
   assign instr_f   = {pc_f[7:0], 24'h00_0F93};
   assign ctrl_d    = instr_d[15:0];
   assign rs1_d     = instr_d[19:15];
   assign rs2_d     = instr_d[24:20];
   assign rd_d      = instr_d[11:7];
   assign rd1_d     = pc_d ^ 32'h1111_1111;
   assign rd2_d     = ~pc_d;
   assign imm_d     = pc_plus4_d;

   pipe_stage_regs #(
      .XLEN(32), .CTRL_W(16), .RESET_PC(32'h0000_0000), .CNT_W(4)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
      .cnt_clr(cnt_clr), .pc_next_f(pc_next_f), .instr_f(instr_f),
      .ctrl_d(ctrl_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
      .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_d(imm_d),
      .pc_f(pc_f), .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
      .valid_d(valid_d), .ctrl_e(ctrl_e), .rs1_e(rs1_e), .rs2_e(rs2_e),
      .rd_e(rd_e), .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_e(imm_e), .pc_e(pc_e),
      .pc_plus4_e(pc_plus4_e), .valid_e(valid_e),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic hazards(input logic sf, input logic sd, input logic fd, input logic fe);
      stall_f = sf;
      stall_d = sd;
      flush_d = fd;
      flush_e = fe;
   endtask

   initial begin
      errors   = 0;
      checks   = 0;
      rst_n    = 1'b0;
      redirect = 1'b0;
      target   = '0;
      cnt_clr  = 1'b0;
      hazards(0, 0, 0, 0);

      #2;
      check("rst_pc_f", pc_f, 32'h0);
      check("rst_valid_d", valid_d, 1'b0);
      check("rst_instr_d", instr_d, 32'h0);
      check("rst_valid_e", valid_e, 1'b0);
      check("rst_stall_cnt", stall_cnt, 4'h0);
      check("rst_flush_cnt", flush_cnt, 4'h0);
      #10 rst_n = 1'b1;

      // free flow
      tick();
      $display("edge1 pc_f=%h instr_d=%h", pc_f, instr_d);
      check("e1_pc_f", pc_f, 32'h4);
      check("e1_instr_d", instr_d, 32'h0000_0F93);
      check("e1_pc_plus4_d", pc_plus4_d, 32'h4);
      check("e1_valid_d", valid_d, 1'b1);
      check("e1_valid_e", valid_e, 1'b0);
      tick();
      $display("edge2 pc_f=%h instr_d=%h ctrl_e=%h", pc_f, instr_d, ctrl_e);
      check("e2_pc_f", pc_f, 32'h8);
      check("e2_instr_d", instr_d, 32'h0400_0F93);
      check("e2_valid_e", valid_e, 1'b1);
      check("e2_ctrl_e", ctrl_e, 16'h0F93);
      check("e2_rd_e", rd_e, 5'd31);
      check("e2_rd1_e", rd1_e, 32'h1111_1111);
      check("e2_rd2_e", rd2_e, 32'hFFFF_FFFF);
      check("e2_imm_e", imm_e, 32'h4);
      check("e2_pc_plus4_e", pc_plus4_e, 32'h4);
      tick();
      tick();
      check("e4_pc_f", pc_f, 32'h10);
      check("e4_pc_e", pc_e, 32'h8);

      // load-use at pc_f = 0x10
      hazards(1, 1, 0, 1);
      tick();
      $display("loaduse pc_f=%h instr_d=%h valid_e=%0d stall_cnt=%0d", pc_f, instr_d, valid_e, stall_cnt);
      check("lu_pc_f", pc_f, 32'h10);
      check("lu_instr_d", instr_d, 32'h0C00_0F93);
      check("lu_pc_d", pc_d, 32'hC);
      check("lu_valid_e", valid_e, 1'b0);
      check("lu_rd_e", rd_e, 5'd0);
      check("lu_ctrl_e", ctrl_e, 16'h0);
      check("lu_stall_cnt", stall_cnt, 4'd1);
      hazards(0, 0, 0, 0);
      tick();
      check("lu2_pc_f", pc_f, 32'h14);
      check("lu2_valid_e", valid_e, 1'b1);
      check("lu2_pc_e", pc_e, 32'hC);
      check("lu2_instr_d", instr_d, 32'h1000_0F93);

      // taken branch to 0x80
      hazards(0, 0, 1, 1);
      redirect = 1'b1;
      target   = 32'h80;
      tick();
      $display("branch pc_f=%h instr_d=%h valid_d=%0d flush_cnt=%0d", pc_f, instr_d, valid_d, flush_cnt);
      check("br_pc_f", pc_f, 32'h80);
      check("br_valid_d", valid_d, 1'b0);
      check("br_instr_d", instr_d, 32'h0000_0013);
      check("br_pc_d", pc_d, 32'h0);
      check("br_valid_e", valid_e, 1'b0);
      check("br_rd_e", rd_e, 5'd0);
      check("br_flush_cnt", flush_cnt, 4'd1);
      check("br_stall_cnt", stall_cnt, 4'd1);
      hazards(0, 0, 0, 0);
      redirect = 1'b0;
      tick();
      check("br2_instr_d", instr_d, 32'h8000_0F93);
      check("br2_valid_e", valid_e, 1'b0);
      tick();
      check("br3_valid_e", valid_e, 1'b1);
      check("br3_pc_e", pc_e, 32'h80);
      check("br3_pc_f", pc_f, 32'h88);

      // stall and flush together: redirect wins, stall not counted
      hazards(1, 1, 1, 0);
      redirect = 1'b1;
      target   = 32'h40;
      tick();
      $display("stall+flush pc_f=%h valid_d=%0d stall_cnt=%0d", pc_f, valid_d, stall_cnt);
      check("sf_pc_f", pc_f, 32'h40);
      check("sf_valid_d", valid_d, 1'b0);
      check("sf_instr_d", instr_d, 32'h0000_0013);
      check("sf_stall_cnt", stall_cnt, 4'd1);
      check("sf_flush_cnt", flush_cnt, 4'd2);

      // PC+4 wraps modulo 2^32
      hazards(0, 0, 1, 0);
      target = 32'hFFFF_FFFC;
      tick();
      check("wr_pc_f", pc_f, 32'hFFFF_FFFC);
      hazards(0, 0, 0, 0);
      redirect = 1'b0;
      tick();
      $display("wrap pc_d=%h pc_plus4_d=%h pc_f=%h", pc_d, pc_plus4_d, pc_f);
      check("wr_pc_d", pc_d, 32'hFFFF_FFFC);
      check("wr_pc_plus4_d", pc_plus4_d, 32'h0);
      check("wr_pc_f2", pc_f, 32'h0);
      check("wr_flush_cnt", flush_cnt, 4'd3);

      // 20 stall cycles: counter goes from 1 and saturates at 15
      hazards(1, 1, 0, 0);
      for (int i = 1; i <= 20; i++) begin
         tick();
         check($sformatf("sat_stall_cnt_%0d", i), stall_cnt, (i + 1 > 15) ? 32'd15 : 32'(i + 1));
      end
      $display("saturate stall_cnt=%0d pc_f=%h", stall_cnt, pc_f);
      check("sat_pc_f", pc_f, 32'h0);
      cnt_clr = 1'b1;
      tick();
      $display("clear stall_cnt=%0d flush_cnt=%0d", stall_cnt, flush_cnt);
      check("clr_stall_cnt", stall_cnt, 4'd0);
      check("clr_flush_cnt", flush_cnt, 4'd0);
      cnt_clr = 1'b0;

      // build some state, then reset asynchronously between edges
      hazards(0, 0, 1, 0);
      redirect = 1'b1;
      target   = 32'h200;
      tick();
      hazards(0, 0, 0, 0);
      redirect = 1'b0;
      tick();
      tick();
      check("pre_rst_valid_e", valid_e, 1'b1);
      check("pre_rst_flush_cnt", flush_cnt, 4'd1);
      check("pre_rst_pc_f", pc_f, 32'h208);
      #3 rst_n = 1'b0;
      #1;
      $display("async reset pc_f=%h valid_d=%0d valid_e=%0d", pc_f, valid_d, valid_e);
      check("ar_pc_f", pc_f, 32'h0);
      check("ar_valid_d", valid_d, 1'b0);
      check("ar_valid_e", valid_e, 1'b0);
      check("ar_instr_d", instr_d, 32'h0);
      check("ar_flush_cnt", flush_cnt, 4'd0);
      #2 rst_n = 1'b1;
      tick();
      check("ar2_pc_f", pc_f, 32'h4);
      check("ar2_instr_d", instr_d, 32'h0000_0F93);
      check("ar2_valid_d", valid_d, 1'b1);
      check("ar2_valid_e", valid_e, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
